// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide synchronous RAM between instruction fetch
// (word reads) and the MEM stage (word loads, byte/half/word stores).
// Each accepted request becomes a run of byte cycles on the RAM port and
// ends with a one-cycle done pulse on the port that owns it.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_r_en_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_done_o,
  output logic              if_busy_o,
  input  logic              mem_r_en_i,
  input  logic              mem_w_en_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [1:0]        mem_mask_i,
  output logic              mem_done_o,
  output logic              mem_busy_o,
  output logic [31:0]       rdata_o,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   base_q;
  logic [31:0]         wdata_q;
  logic [2:0]          nbytes_q;
  logic [23:0]         rbuf_q;
  logic [31:0]         rdata_q;
  logic                if_done_q;
  logic                mem_done_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   ram_a_q;
  logic [7:0]          ram_dout_q;
  logic                ram_wr_q;
  logic [ADDR_W-1:0]   addr_next_d;

  // Store size decode: number of bytes written for a given mask.
  function automatic logic [2:0] mask_len(input logic [1:0] mask);
    logic [2:0] len;
    case (mask)
      2'b01:   len = 3'd1;
      2'b10:   len = 3'd2;
      2'b11:   len = 3'd4;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

  // Little-endian byte select from a 32-bit word.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Address of the byte following the current one; wraps modulo 2^ADDR_W.
  always_comb begin
    addr_next_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
  end

  // Arbitration, byte sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      owner_q    <= OWNER_IF;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      nbytes_q   <= 3'd0;
      rbuf_q     <= 24'h0;
      rdata_q    <= 32'h0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      busy_q     <= 1'b0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'h00;
      ram_wr_q   <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q      <= 3'd0;
          ram_a_q    <= '0;
          ram_dout_q <= 8'h00;
          ram_wr_q   <= 1'b0;
          busy_q     <= 1'b0;
          if (mem_w_en_i) begin
            owner_q  <= OWNER_MEM;
            base_q   <= mem_addr_i[ADDR_W-1:0];
            wdata_q  <= mem_wdata_i;
            nbytes_q <= mask_len(mem_mask_i);
            if (mask_len(mem_mask_i) == 3'd0) begin
              // Empty store: nothing to write, complete immediately.
              mem_done_q <= 1'b1;
            end else begin
              state_q    <= S_WR;
              busy_q     <= 1'b1;
              ram_a_q    <= mem_addr_i[ADDR_W-1:0];
              ram_dout_q <= mem_wdata_i[7:0];
              ram_wr_q   <= 1'b1;
            end
          end else if (mem_r_en_i) begin
            owner_q <= OWNER_MEM;
            base_q  <= mem_addr_i[ADDR_W-1:0];
            state_q <= S_RD;
            busy_q  <= 1'b1;
            ram_a_q <= mem_addr_i[ADDR_W-1:0];
          end else if (if_r_en_i) begin
            owner_q <= OWNER_IF;
            base_q  <= if_addr_i[ADDR_W-1:0];
            state_q <= S_RD;
            busy_q  <= 1'b1;
            ram_a_q <= if_addr_i[ADDR_W-1:0];
          end
        end
        S_RD: begin
          // ram_din lags the address by one cycle, so byte cnt-1 arrives now.
          case (cnt_q)
            3'd1:    rbuf_q[7:0]   <= ram_din;
            3'd2:    rbuf_q[15:8]  <= ram_din;
            3'd3:    rbuf_q[23:16] <= ram_din;
            default: rbuf_q        <= rbuf_q;
          endcase
          if (cnt_q == 3'd4) begin
            rdata_q    <= {ram_din, rbuf_q};
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            busy_q     <= 1'b0;
            ram_a_q    <= '0;
            if_done_q  <= (owner_q == OWNER_IF);
            mem_done_q <= (owner_q == OWNER_MEM);
          end else if (cnt_q == 3'd3) begin
            // Last byte already addressed; the final cycle only captures.
            cnt_q   <= cnt_q + 3'd1;
            ram_a_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            ram_a_q <= addr_next_d;
          end
        end
        S_WR: begin
          if ((cnt_q + 3'd1) == nbytes_q) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            busy_q     <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= 8'h00;
            ram_wr_q   <= 1'b0;
            if_done_q  <= (owner_q == OWNER_IF);
            mem_done_q <= (owner_q == OWNER_MEM);
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            ram_a_q    <= addr_next_d;
            ram_dout_q <= sel_byte(wdata_q, cnt_q[1:0] + 2'd1);
            ram_wr_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= 3'd0;
          busy_q   <= 1'b0;
          ram_a_q  <= '0;
          ram_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_done_o  = if_done_q;
  assign mem_done_o = mem_done_q;
  assign if_busy_o  = busy_q;
  assign mem_busy_o = busy_q;
  assign rdata_o    = rdata_q;
  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;
  assign ram_wr     = ram_wr_q;

endmodule
